bal_seq: RTL

BAL_SEQ -- requirements
Module: bal_seq

---
 rtl/bal_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bal_seq.sv
// Balance-platform power sequencer: IDLE -> SOFT -> RUN with tilt and watchdog fault handling.
// Define BAL_WDOG_EN to build the inertial-sample watchdog; otherwise faults are tilt only.
module bal_seq #(
  parameter logic [15:0] TILT_LIM = 16'h0800,
  parameter int unsigned TILT_CNT = 4,
  parameter logic [19:0] WD_CYC   = 20'd50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic               rider_pres,
  input  logic               inert_vld,
  input  logic signed [15:0] ptch,
  input  logic [7:0]         ss_tmr,
  output logic               pwr_up,
  output logic               rider_off,
  output logic               pid_vld,
  output logic               run,
  output logic               fault,
  output logic [1:0]         fault_src,
  output logic [1:0]         state
);

  localparam int unsigned DATA_W   = 16;
  localparam logic [3:0]  TCNT_MAX = TILT_CNT[3:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOFT  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t st_q, st_d;

  logic en_meta, en_s;
  logic rp_meta, rp_s;

  logic       active;
  logic       tilt_over;
  logic       tilt_flt;
  logic       wd_flt;
  logic       any_flt;
  logic       cnt_clr;
  logic [3:0] tcnt_q;
  logic       src_tilt_q;

  // Magnitude of a signed sample; the most negative code saturates to the largest positive one.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x[DATA_W-1])
      return $unsigned(neg);
    else
      return $unsigned(x);
  endfunction

  // Input synchronizers for the asynchronous switch and load-cell levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      rp_meta <= 1'b0;
      rp_s    <= 1'b0;
    end else begin
      en_meta <= en_req;
      en_s    <= en_meta;
      rp_meta <= rider_pres;
      rp_s    <= rp_meta;
    end
  end

  assign active    = (st_q == SOFT) || (st_q == RUN);
  assign tilt_over = sat_abs(ptch) > TILT_LIM;
  assign tilt_flt  = active && (tcnt_q == TCNT_MAX);
  assign any_flt   = tilt_flt || wd_flt;

`ifdef BAL_WDOG_EN
  localparam logic [19:0] WD_LAST = WD_CYC - 20'd1;

  logic [19:0] wcnt_q;
  logic        src_wd_q;

  assign wd_flt = active && !inert_vld && (wcnt_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else if (cnt_clr) begin
      wcnt_q <= '0;
    end else if (active) begin
      if (inert_vld)
        wcnt_q <= '0;
      else if (wcnt_q != WD_LAST)
        wcnt_q <= wcnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      src_wd_q <= 1'b0;
    else if (st_q != FAULT && st_d == FAULT)
      src_wd_q <= wd_flt;
    else if (st_q == FAULT && st_d == IDLE)
      src_wd_q <= 1'b0;
  end

  assign fault_src = {src_wd_q, src_tilt_q};
`else
  assign wd_flt    = 1'b0;
  assign fault_src = {1'b0, src_tilt_q};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st_q <= IDLE;
    else
      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:  if (en_s && rp_s) st_d = SOFT;
      SOFT: begin
        if (any_flt)                st_d = FAULT;
        else if (!en_s || !rp_s)    st_d = IDLE;
        else if (ss_tmr == 8'hFF)   st_d = RUN;
      end
      RUN: begin
        if (any_flt)                st_d = FAULT;
        else if (!en_s || !rp_s)    st_d = IDLE;
      end
      FAULT: if (!en_s) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Counters restart whenever the sequencer falls back to IDLE or FAULT
  assign cnt_clr = (st_d == IDLE) || (st_d == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (cnt_clr) begin
      tcnt_q <= '0;
    end else if (active && inert_vld) begin
      if (!tilt_over)
        tcnt_q <= '0;
      else if (tcnt_q != TCNT_MAX)
        tcnt_q <= tcnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      src_tilt_q <= 1'b0;
    else if (st_q != FAULT && st_d == FAULT)
      src_tilt_q <= tilt_flt;
    else if (st_q == FAULT && st_d == IDLE)
      src_tilt_q <= 1'b0;
  end

  // Output decode from the registered state; pid_vld is the only input-dependent output
  assign state     = st_q;
  assign pwr_up    = active;
  assign run       = (st_q == RUN);
  assign rider_off = (st_q == IDLE) || (st_q == FAULT);
  assign fault     = (st_q == FAULT);
  assign pid_vld   = inert_vld && active;

endmodule
